// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of JK cells: set/clear/toggle/load masks
// and multi-step synchronous up/down counting, with the bank state held locally.
module jk_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [7:0]       cmd_count,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_SET    = 3'd1;
    localparam logic [2:0] OP_CLEAR  = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DN     = 3'd6;

    state_t           state_reg;
    state_t           state_next;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [7:0]       remaining_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH:0]   up_chain;
    logic [WIDTH:0]   dn_chain;
    logic             accept;

    assign cmd_ready = (state_reg == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // Bit i of a counter toggles when every lower bit is 1 (up) or 0 (down).
    assign up_chain[0] = 1'b1;
    assign dn_chain[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            assign up_chain[gi+1] = up_chain[gi] & q_reg[gi];
            assign dn_chain[gi+1] = dn_chain[gi] & ~q_reg[gi];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            always_comb begin
                unique case ({j[gi], k[gi]})
                    2'b00:   q_next[gi] = q_reg[gi];
                    2'b01:   q_next[gi] = 1'b0;
                    2'b10:   q_next[gi] = 1'b1;
                    default: q_next[gi] = ~q_reg[gi];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= OP_NOP;
            data_reg      <= '0;
            remaining_reg <= '0;
            q_reg         <= '1;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            if (accept) begin
                op_reg        <= cmd_op;
                data_reg      <= cmd_data;
                remaining_reg <= cmd_count;
            end else if (state_reg == COUNT) begin
                remaining_reg <= remaining_reg - 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_SET, OP_CLEAR, OP_TOGGLE, OP_LOAD: state_next = APPLY;
                        OP_UP, OP_DN: state_next = (cmd_count != 8'd0) ? COUNT : DONE;
                        default: state_next = DONE;
                    endcase
                end
            end
            APPLY:   state_next = DONE;
            COUNT:   state_next = (remaining_reg == 8'd1) ? DONE : COUNT;
            default: state_next = IDLE;
        endcase
    end

    // A reset cycle forces the drive quiet so an aborted command never reaches the cells.
    always_comb begin
        j    = '0;
        k    = '0;
        done = 1'b0;
        busy = (state_reg != IDLE);
        if (!rst) begin
            unique case (state_reg)
                APPLY: begin
                    unique case (op_reg)
                        OP_SET:    j = data_reg;
                        OP_CLEAR:  k = data_reg;
                        OP_TOGGLE: begin
                            j = data_reg;
                            k = data_reg;
                        end
                        OP_LOAD: begin
                            j = data_reg;
                            k = ~data_reg;
                        end
                        default: ;
                    endcase
                end
                COUNT: begin
                    if (op_reg == OP_UP) begin
                        j = up_chain[WIDTH-1:0];
                        k = up_chain[WIDTH-1:0];
                    end else begin
                        j = dn_chain[WIDTH-1:0];
                        k = dn_chain[WIDTH-1:0];
                    end
                end
                DONE:    done = 1'b1;
                default: ;
            endcase
        end
    end

    assign q     = q_reg;
    assign q_bar = ~q_reg;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench for jk_bank_sequencer: directed scenarios plus random
// command streams checked against an arithmetic model of the bank value.
module tb_jk_bank_sequencer;
    localparam int W = 4;
    localparam logic [W-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_data = '0;
    logic [7:0]   cmd_count = 8'd0;
    logic [W-1:0] j, k, q, q_bar;
    logic         busy, done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [W-1:0] model_q = ONES;

    jk_bank_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .j(j), .k(k), .q(q), .q_bar(q_bar), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Issue one command (called just after a negedge) and check every cycle until idle again.
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data,
                           input logic [7:0] cnt, input bit noise, output int hs_cyc);
        int exp_n;
        int waited;
        logic [W-1:0] ej, ek, qn, t;
        bit busy_e, done_e;
        hs_cyc = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake_timeout op=%0d ready=%b required=1", op, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (op >= 3'd1 && op <= 3'd4) exp_n = 1;
        else if ((op == 3'd5 || op == 3'd6) && cnt != 8'd0) exp_n = int'(cnt);
        else exp_n = 0;
        for (int n = 0; n <= exp_n + 1; n++) begin
            @(negedge clk);
            if (n == 0) hs_cyc = cyc;
            busy_e = (n <= exp_n);
            done_e = (n == exp_n);
            ej = '0; ek = '0; qn = model_q;
            if (n < exp_n) begin
                case (op)
                    3'd1: begin ej = data; qn = model_q | data; end
                    3'd2: begin ek = data; qn = model_q & ~data; end
                    3'd3: begin ej = data; ek = data; qn = model_q ^ data; end
                    3'd4: begin ej = data; ek = ~data; qn = data; end
                    3'd5: begin t = model_q + 1'b1; ej = model_q ^ t; ek = ej; qn = t; end
                    default: begin t = model_q - 1'b1; ej = model_q ^ t; ek = ej; qn = t; end
                endcase
            end
            checks++;
            if (q !== model_q) begin
                failures++;
                $display("FAIL q op=%0d step=%0d got=%b expected=%b", op, n, q, model_q);
            end
            checks++;
            if (q_bar !== ~model_q) begin
                failures++;
                $display("FAIL q_bar op=%0d step=%0d got=%b expected=%b", op, n, q_bar, ~model_q);
            end
            checks++;
            if (j !== ej) begin
                failures++;
                $display("FAIL j op=%0d step=%0d got=%b expected=%b", op, n, j, ej);
            end
            checks++;
            if (k !== ek) begin
                failures++;
                $display("FAIL k op=%0d step=%0d got=%b expected=%b", op, n, k, ek);
            end
            checks++;
            if (done !== done_e) begin
                failures++;
                $display("FAIL done op=%0d step=%0d got=%b expected=%b", op, n, done, done_e);
            end
            checks++;
            if (busy !== busy_e) begin
                failures++;
                $display("FAIL busy op=%0d step=%0d got=%b expected=%b", op, n, busy, busy_e);
            end
            checks++;
            if (cmd_ready !== !busy_e) begin
                failures++;
                $display("FAIL cmd_ready op=%0d step=%0d got=%b expected=%b", op, n, cmd_ready, !busy_e);
            end
            model_q = qn;
            if (noise && n <= exp_n) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 3'($urandom);
                cmd_data  = W'($urandom);
                cmd_count = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready cycle=%0d got=%b expected=0", n, cmd_ready);
            end
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || j !== '0 || k !== '0) begin
                failures++;
                $display("FAIL reset_outputs got done=%b busy=%b j=%b k=%b expected all zero", done, busy, j, k);
            end
        end
        checks++;
        if (q !== 4'b1111 || q_bar !== 4'b0000) begin
            failures++;
            $display("FAIL reset_q got q=%b q_bar=%b expected q=1111 q_bar=0000", q, q_bar);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b expected=1", cmd_ready);
        end
        model_q = ONES;
    endtask

    task automatic test_load_toggle();
        int hs;
        run_cmd(3'd4, 4'b1010, 8'd0, 1'b0, hs);
        run_cmd(3'd3, 4'b0110, 8'd0, 1'b0, hs);
        checks++;
        if (q !== 4'b1100) begin
            failures++;
            $display("FAIL load_toggle_result got=%b expected=1100", q);
        end
    endtask

    task automatic test_count_up_wrap();
        int hs;
        run_cmd(3'd4, 4'b1110, 8'd0, 1'b0, hs);
        run_cmd(3'd5, 4'b0000, 8'd3, 1'b0, hs);
        checks++;
        if (q !== 4'b0001) begin
            failures++;
            $display("FAIL count_up_wrap got=%b expected=0001", q);
        end
    endtask

    task automatic test_count_dn();
        int hs;
        run_cmd(3'd4, 4'b0001, 8'd0, 1'b0, hs);
        run_cmd(3'd6, 4'b0000, 8'd2, 1'b0, hs);
        checks++;
        if (q !== 4'b1111) begin
            failures++;
            $display("FAIL count_dn_wrap got=%b expected=1111", q);
        end
    endtask

    task automatic test_nop_zero();
        int hs;
        run_cmd(3'd5, 4'b1111, 8'd0, 1'b0, hs);
        run_cmd(3'd7, 4'b1111, 8'd9, 1'b0, hs);
        run_cmd(3'd0, 4'b0101, 8'd4, 1'b0, hs);
        run_cmd(3'd6, 4'b0101, 8'd0, 1'b0, hs);
    endtask

    task automatic test_ignore_busy();
        int hs;
        run_cmd(3'd5, 4'b0000, 8'd5, 1'b1, hs);
    endtask

    task automatic test_back_to_back();
        int hs1, hs2;
        run_cmd(3'd1, 4'b0011, 8'd0, 1'b0, hs1);
        run_cmd(3'd2, 4'b0110, 8'd0, 1'b0, hs2);
        checks++;
        if (hs2 - hs1 !== 3) begin
            failures++;
            $display("FAIL back_to_back_spacing got=%0d expected=3", hs2 - hs1);
        end
    endtask

    task automatic test_reset_abort();
        int hs;
        run_cmd(3'd4, 4'b0000, 8'd0, 1'b0, hs);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = '0; cmd_count = 8'd10;
        @(posedge clk);
        for (int n = 0; n <= 4; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++;
            if (q !== W'(n)) begin
                failures++;
                $display("FAIL abort_progress step=%0d got=%b expected=%b", n, q, W'(n));
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (j !== '0 || k !== '0 || cmd_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_during_rst got j=%b k=%b ready=%b done=%b expected 0000 0000 0 0", j, k, cmd_ready, done);
        end
        @(negedge clk);
        checks++;
        if (q !== 4'b1111 || q_bar !== 4'b0000) begin
            failures++;
            $display("FAIL abort_q got q=%b q_bar=%b expected q=1111 q_bar=0000", q, q_bar);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || j !== '0 || k !== '0) begin
            failures++;
            $display("FAIL abort_outputs got done=%b busy=%b j=%b k=%b expected all zero", done, busy, j, k);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready got=%b expected=1", cmd_ready);
        end
        model_q = ONES;
        run_cmd(3'd4, 4'b0110, 8'd0, 1'b0, hs);
    endtask

    task automatic test_random();
        int hs;
        logic [2:0] op;
        logic [7:0] cnt;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom);
            cnt = 8'($urandom_range(0, 12));
            run_cmd(op, W'($urandom), cnt, 1'($urandom_range(0, 1)), hs);
        end
    endtask

    initial begin
        test_reset();
        test_load_toggle();
        test_count_up_wrap();
        test_count_dn();
        test_nop_zero();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
